// File: rtl/fetch_sequencer.sv
// PC register and single-outstanding instruction fetch sequencer.
// Holds each fetched word for decode; redirects flush stale responses.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state, state_n;
    logic        drop, drop_n;
    logic [31:0] pc_n;
    logic [31:0] inst_data_n;
    logic [31:0] inst_pc_n;
    logic [31:0] redir_pc;
    logic        fire;

    assign redir_pc       = redirect_pc & 32'hFFFF_FFFC;
    assign imem_req_valid = (state == REQ);
    assign inst_valid     = (state == HOLD);
    assign imem_req_addr  = pc;
    assign fire           = imem_req_valid & imem_req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            inst_data <= 32'h0;
            inst_pc   <= 32'h0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            drop      <= drop_n;
            inst_data <= inst_data_n;
            inst_pc   <= inst_pc_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        drop_n      = drop;
        inst_data_n = inst_data;
        inst_pc_n   = inst_pc;
        unique case (state)
            IDLE: begin
                state_n = REQ;
                if (redirect_valid) pc_n = redir_pc;
            end
            REQ: begin
                if (redirect_valid) pc_n = redir_pc;
                if (fire) begin
                    state_n = WAIT;
                    drop_n  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    // a redirect alongside the response makes it stale too
                    if (drop || redirect_valid) begin
                        drop_n  = 1'b0;
                        state_n = REQ;
                        if (redirect_valid) pc_n = redir_pc;
                    end else begin
                        inst_data_n = imem_resp_data;
                        inst_pc_n   = pc;
                        pc_n        = pc + 32'd4;
                        state_n     = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_n   = redir_pc;
                    drop_n = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_n    = redir_pc;
                    state_n = REQ;
                end else if (inst_ready) begin
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against a
// program-order model: next expected PC, memory image, redirects.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] pc;

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;

    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    logic [31:0] fire_q[$];
    logic [31:0] acc_pc_q[$];
    logic [31:0] acc_data_q[$];

    fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .pc             (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] getq(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic clear_q();
        fire_q.delete();
        acc_pc_q.delete();
        acc_data_q.delete();
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
        pend            = 1'b0;
        cnt             = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        clear_q();
    endtask

    // drive one cycle of inputs; memory model answers after lat cycles
    task automatic cycle(input logic rq, input logic ir, input logic rd,
                         input logic [31:0] rpc, input int lat);
        logic fire, acc;
        imem_req_ready  = rq;
        inst_ready      = ir;
        redirect_valid  = rd;
        redirect_pc     = rpc;
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (pend) begin
            if (cnt <= 1) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem(paddr);
                pend            = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end
        fire = imem_req_valid & rq;
        acc  = inst_valid & ir & ~rd;
        if (fire) begin
            fire_q.push_back(imem_req_addr);
            pend  = 1'b1;
            cnt   = lat;
            paddr = imem_req_addr;
        end
        if (acc) begin
            acc_pc_q.push_back(inst_pc);
            acc_data_q.push_back(inst_data);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        logic [31:0] vq[$];
        do_reset();
        asserts++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_valids: got %b expected 00", {imem_req_valid, inst_valid});
        end
        asserts++;
        if (pc !== RST_PC || imem_req_addr !== RST_PC) begin
            fails++;
            $display("FAIL reset_pc: got %h/%h expected %h", pc, imem_req_addr, RST_PC);
        end
        asserts++;
        if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_inst: got %h/%h expected 0/0", inst_data, inst_pc);
        end
        for (int i = 0; i < 10; i++) begin
            if (inst_valid) vq.push_back(cyc);
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        end
        for (int i = 0; i < 3; i++) begin
            asserts++;
            if (getq(vq, i) !== 32'(3 * i + 3)) begin
                fails++;
                $display("FAIL best_case_valid_cycle[%0d]: got %0d expected %0d", i, getq(vq, i), 3 * i + 3);
            end
            asserts++;
            if (getq(fire_q, i) !== RST_PC + 32'(4 * i)) begin
                fails++;
                $display("FAIL best_case_req[%0d]: got %h expected %h", i, getq(fire_q, i), RST_PC + 32'(4 * i));
            end
            asserts++;
            if (getq(acc_pc_q, i) !== RST_PC + 32'(4 * i) ||
                getq(acc_data_q, i) !== mem(RST_PC + 32'(4 * i))) begin
                fails++;
                $display("FAIL best_case_inst[%0d]: got %h/%h expected %h/%h", i, getq(acc_pc_q, i),
                         getq(acc_data_q, i), RST_PC + 32'(4 * i), mem(RST_PC + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            asserts++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
                fails++;
                $display("FAIL req_stall[%0d]: got v=%b a=%h expected v=1 a=%h", i, imem_req_valid, imem_req_addr, RST_PC);
            end
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        for (int i = 0; i < 5; i++) begin
            asserts++;
            if (inst_valid !== 1'b1 || inst_pc !== RST_PC || inst_data !== mem(RST_PC)) begin
                fails++;
                $display("FAIL hold_stall[%0d]: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h", i, inst_valid,
                         inst_pc, inst_data, RST_PC, mem(RST_PC));
            end
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        end
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        asserts++;
        if (acc_pc_q.size() != 2 || getq(acc_pc_q, 0) !== RST_PC || getq(acc_pc_q, 1) !== RST_PC + 32'd4) begin
            fails++;
            $display("FAIL backpressure_delivery: got n=%0d %h %h expected n=2 %h %h", acc_pc_q.size(),
                     getq(acc_pc_q, 0), getq(acc_pc_q, 1), RST_PC, RST_PC + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 3);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 3);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_2002, 3);
        asserts++;
        if (pc !== 32'h0000_2000) begin
            fails++;
            $display("FAIL wait_redirect_pc: got %h expected 00002000", pc);
        end
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        asserts++;
        if (getq(fire_q, 1) !== 32'h0000_2000) begin
            fails++;
            $display("FAIL wait_redirect_req: got %h expected 00002000", getq(fire_q, 1));
        end
        asserts++;
        if (getq(acc_pc_q, 0) !== 32'h0000_2000 || getq(acc_data_q, 0) !== mem(32'h0000_2000)) begin
            fails++;
            $display("FAIL wait_redirect_inst: got %h/%h expected 00002000/%h", getq(acc_pc_q, 0),
                     getq(acc_data_q, 0), mem(32'h0000_2000));
        end
    endtask

    task automatic test_redirect_fire();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        asserts++;
        if (getq(fire_q, 0) !== RST_PC || getq(fire_q, 1) !== 32'h0000_0400) begin
            fails++;
            $display("FAIL fire_redirect_req: got %h %h expected %h 00000400", getq(fire_q, 0), getq(fire_q, 1), RST_PC);
        end
        asserts++;
        if (getq(acc_pc_q, 0) !== 32'h0000_0400 || getq(acc_data_q, 0) !== mem(32'h0000_0400)) begin
            fails++;
            $display("FAIL fire_redirect_inst: got %h/%h expected 00000400/%h", getq(acc_pc_q, 0),
                     getq(acc_data_q, 0), mem(32'h0000_0400));
        end
    endtask

    task automatic test_hold_redirect();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        asserts++;
        if (inst_valid !== 1'b1) begin
            fails++;
            $display("FAIL hold_reached: got %b expected 1", inst_valid);
        end
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0080, 1);
        asserts++;
        if (inst_valid !== 1'b0 || pc !== 32'h0000_0080 || acc_pc_q.size() != 0) begin
            fails++;
            $display("FAIL hold_redirect: got v=%b pc=%h n=%0d expected v=0 pc=00000080 n=0", inst_valid, pc, acc_pc_q.size());
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        asserts++;
        if (getq(fire_q, 1) !== 32'h0000_0080 || acc_pc_q.size() != 1 || getq(acc_pc_q, 0) !== 32'h0000_0080) begin
            fails++;
            $display("FAIL hold_redirect_next: got req=%h n=%0d pc=%h expected req=00000080 n=1 pc=00000080",
                     getq(fire_q, 1), acc_pc_q.size(), getq(acc_pc_q, 0));
        end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1);
        asserts++;
        if (pc !== 32'hFFFF_FFFC) begin
            fails++;
            $display("FAIL idle_redirect_pc: got %h expected fffffffc", pc);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        asserts++;
        if (inst_pc !== 32'hFFFF_FFFC || inst_data !== mem(32'hFFFF_FFFC) || pc !== 32'h0) begin
            fails++;
            $display("FAIL wrap: got ipc=%h d=%h pc=%h expected fffffffc/%h/00000000", inst_pc, inst_data, pc, mem(32'hFFFF_FFFC));
        end
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        asserts++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            fails++;
            $display("FAIL wrap_req: got v=%b a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr);
        end
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 3);
        do_reset();
        asserts++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== RST_PC || imem_req_addr !== RST_PC ||
            inst_pc !== 32'h0 || inst_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_in_wait: got rv=%b iv=%b pc=%h ipc=%h d=%h expected 0 0 %h 0 0",
                     imem_req_valid, inst_valid, pc, inst_pc, inst_data, RST_PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] next_pc, rpc, p_addr, p_ipc, p_idata;
        logic        rq, ir, rd, p_req_stall, p_hold_stall;
        int          lat, delivered;
        do_reset();
        next_pc      = RST_PC;
        p_req_stall  = 1'b0;
        p_hold_stall = 1'b0;
        p_addr       = 32'h0;
        p_ipc        = 32'h0;
        p_idata      = 32'h0;
        delivered    = 0;
        for (int i = 0; i < 3000; i++) begin
            rq  = ($urandom_range(0, 3) != 0);
            ir  = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            lat = $urandom_range(1, 4);
            if (p_req_stall) begin
                asserts++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== p_addr) begin
                    fails++;
                    $display("FAIL rnd_req_stable: got v=%b a=%h expected v=1 a=%h", imem_req_valid, imem_req_addr, p_addr);
                end
            end
            if (p_hold_stall) begin
                asserts++;
                if (inst_valid !== 1'b1 || inst_pc !== p_ipc || inst_data !== p_idata) begin
                    fails++;
                    $display("FAIL rnd_hold_stable: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h", inst_valid, inst_pc,
                             inst_data, p_ipc, p_idata);
                end
            end
            if (imem_req_valid && rq && !rd) begin
                asserts++;
                if (imem_req_addr !== next_pc) begin
                    fails++;
                    $display("FAIL rnd_req_addr: got %h expected %h", imem_req_addr, next_pc);
                end
            end
            if (inst_valid && ir && !rd) begin
                asserts++;
                if (inst_pc !== next_pc || inst_data !== mem(next_pc)) begin
                    fails++;
                    $display("FAIL rnd_inst: got %h/%h expected %h/%h", inst_pc, inst_data, next_pc, mem(next_pc));
                end
                next_pc = next_pc + 32'd4;
                delivered++;
            end
            if (rd) next_pc = rpc & 32'hFFFF_FFFC;
            p_req_stall  = imem_req_valid && !rq && !rd;
            p_hold_stall = inst_valid && !ir && !rd;
            p_addr       = imem_req_addr;
            p_ipc        = inst_pc;
            p_idata      = inst_data;
            cycle(rq, ir, rd, rpc, lat);
        end
        asserts++;
        if (delivered < 50) begin
            fails++;
            $display("FAIL rnd_progress: got %0d deliveries expected at least 50", delivered);
        end
    endtask

    initial begin
        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
        pend            = 1'b0;
        cnt             = 0;
        paddr           = 32'h0;
        test_reset();
        test_backpressure();
        test_redirect_wait();
        test_redirect_fire();
        test_hold_redirect();
        test_wrap_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the program counter and instruction fetch for the RISC-V core. It owns the PC register, issues one instruction-memory request at a time over a valid/ready handshake, and holds each returned instruction until the decode stage accepts it. It applies branch/jump redirects at any point in the fetch and discards any stale response.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  instruction memory accepts the request.
- imem_req_addr  out  32  fetch address; always equals pc.
- imem_resp_valid  in  1  response valid; arrives at least 1 cycle after acceptance; at most one outstanding.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  single-cycle pulse: replace the fetch PC.
- redirect_pc  in  32  new PC; bits [1:0] are ignored and stored as 0.
- inst_valid  out  1  fetched instruction available to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst_data  out  32  held instruction word.
- inst_pc  out  32  PC of inst_data.
- pc  out  32  current fetch PC register.

## Operation
- Registers: state, pc, drop flag, inst_data, inst_pc.
- States: IDLE, REQ, WAIT, HOLD.
- Reset: state=IDLE, pc=RESET_PC, drop=0, inst_data=0, inst_pc=0. Outputs: imem_req_valid=0, inst_valid=0.
- IDLE: all outputs idle. Go to REQ on the next edge. A redirect_valid in IDLE loads pc.
- REQ: imem_req_valid=1.
  - fire = imem_req_valid & imem_req_ready.
  - fire without redirect: go to WAIT with drop=0.
  - redirect without fire: pc<=redirect_pc; stay in REQ. The next request uses the new pc.
  - fire and redirect together: pc<=redirect_pc; go to WAIT with drop=1.
- WAIT: imem_req_valid=0. Wait for imem_resp_valid.
  - Redirect without a response: pc<=redirect_pc; drop<=1; stay in WAIT.
  - Response with drop=1, or with redirect_valid in the same cycle: discard it. Clear drop, load pc from redirect_pc if a redirect is present, go to REQ.
  - Response otherwise: inst_data<=imem_resp_data, inst_pc<=pc, pc<=pc+4; go to HOLD.
- HOLD: inst_valid=1. inst_data and inst_pc stay stable while inst_valid=1 and inst_ready=0.
  - Redirect: pc<=redirect_pc; go to REQ. The instruction is discarded even if inst_ready=1; redirect has priority.
  - inst_ready=1 without redirect: go to REQ.
  - Otherwise stay in HOLD.
- PC arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. pc[1:0] is always 0.
- Reset asserted in any state: on the next edge, return to the reset values. An outstanding response arriving in IDLE after reset is ignored; the bench must not send one.

## Timing
- imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc and pc are driven only from registers. There is no combinational path from any input to any output.
- imem_req_valid stays high in REQ until accepted. imem_req_addr is stable while imem_req_valid=1 and imem_req_ready=0, unless a redirect changes pc.
- Best-case sequence with ready=1 and a 1-cycle response:
  - cycle 0 after reset release: IDLE.
  - cycle 1: REQ; request accepted.
  - cycle 2: WAIT; response arrives.
  - cycle 3: HOLD; inst_valid=1, accepted.
  - cycle 4: REQ for pc+4.
- Throughput is one instruction per 3 cycles when memory and decode are never stalled.
- A redirect costs 1 cycle in REQ. In HOLD, REQ at the new pc follows on the next cycle. In WAIT, the cost is the remaining response latency plus 1 cycle.

## Test plan
- Reset: RESET_PC=32'h0000_0100, ready=1, response latency 1, decode always ready → requests at 0x100, 0x104, 0x108. inst_valid asserted at cycles 3, 6, 9 with matching inst_pc and data.
- Backpressure: imem_req_ready low for 4 cycles, then inst_ready low for 5 cycles → imem_req_addr stable throughout. inst_valid, inst_data and inst_pc held stable. No instruction is lost or duplicated.
- Redirect in WAIT: request 0x100 accepted, redirect to 0x2002 before the response → the 0x100 response is discarded. The next request address is 0x2000. The first delivered inst_pc is 0x2000.
- Redirect in the fire cycle: redirect to 0x400 in the same cycle the 0x100 request fires → the response is dropped and the next request is 0x400.
- HOLD redirect vs accept: inst_ready=1 and redirect to 0x80 in the same cycle → the instruction is not counted as delivered. The next request is 0x80.
- Wrap and reset: pc=0xFFFF_FFFC fetch completes → pc becomes 0x0000_0000. Asserting reset while in WAIT → all outputs return to reset values on the next edge.
